// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - read-modify-write data-memory bridge; DMEM_TIMEOUT_EN adds a per-phase bus timeout
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_fault,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        err_flag;
    logic        err_flag_nx;
    logic [31:0] rdata_nx;
    logic        phase_timeout;

    assign bus_req   = (state == S_RD) || (state == S_WR);
    assign bus_we    = (state == S_WR);
    assign bus_addr  = req_addr;
    assign bus_wdata = (state == S_WR) ? req_wdata : 32'h0;
    assign done      = (state == S_DONE);
    assign err       = done & err_flag;
    assign stall     = req_valid & (state != S_DONE);

`ifdef DMEM_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    // Any state change clears the counter, so it starts at zero in every RD/WR phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 16'h0;
        end else if (state_nx != state) begin
            wait_cnt <= 16'h0;
        end else if (bus_req && !bus_ack) begin
            wait_cnt <= wait_cnt + 16'h1;
        end
    end

    assign phase_timeout = bus_req && !bus_ack && (wait_cnt == WAIT_LAST);
`else
    assign phase_timeout = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        err_flag_nx = err_flag;
        rdata_nx    = rdata;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_nx    = S_DONE;
                        err_flag_nx = 1'b1;
                    end else begin
                        state_nx = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus_ack) begin
                    if (bus_err) begin
                        state_nx    = S_DONE;
                        err_flag_nx = 1'b1;
                    end else begin
                        rdata_nx = bus_rdata;
                        state_nx = req_write ? S_MERGE : S_DONE;
                    end
                end else if (phase_timeout) begin
                    state_nx    = S_DONE;
                    err_flag_nx = 1'b1;
                end
            end
            // mem_unit rebuilds its store word from the freshly read rdata here.
            S_MERGE: state_nx = S_WR;
            S_WR: begin
                if (bus_ack) begin
                    state_nx    = S_DONE;
                    err_flag_nx = bus_err;
                end else if (phase_timeout) begin
                    state_nx    = S_DONE;
                    err_flag_nx = 1'b1;
                end
            end
            S_DONE: begin
                state_nx    = S_IDLE;
                err_flag_nx = 1'b0;
            end
            default: begin
                state_nx    = S_IDLE;
                err_flag_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            err_flag <= 1'b0;
            rdata    <= 32'h0;
        end else begin
            state    <= state_nx;
            err_flag <= err_flag_nx;
            rdata    <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - scoreboard bench for dmem_bridge with a wait-state bus responder
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_fault = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall, done, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    // bus responder controls and observations
    int          wait_rd = 0, wait_wr = 0, wcnt = 0;
    bit          hang_rd = 0, hang_wr = 0, err_rd = 0, err_wr = 0;
    logic [31:0] rd_word = 32'h0;
    int          req_cycles = 0, wr_count = 0;
    logic [31:0] wr_data = 32'h0, first_addr = 32'h0;
    bit          first_seen = 0;
    bit          sb_mode = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
        int          writes;
        int          reqs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // mem_unit stand-in: SB of 0xFF into byte 3 of the word read back
    always_comb req_wdata = sb_mode ? {8'hFF, rdata[23:0]} : rdata;

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_fault(req_fault),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always @(negedge clk) begin
        if (bus_req) req_cycles++;
        if (bus_req && !first_seen) begin
            first_addr = bus_addr;
            first_seen = 1;
        end
        if (bus_ack) begin
            bus_ack = 1'b0;
            bus_err = 1'b0;
            wcnt    = 0;
        end else if (bus_req && !(bus_we ? hang_wr : hang_rd)) begin
            if (wcnt >= (bus_we ? wait_wr : wait_rd)) begin
                bus_ack   = 1'b1;
                bus_err   = bus_we ? err_wr : err_rd;
                bus_rdata = rd_word;
                if (bus_we) begin
                    wr_count++;
                    wr_data = bus_wdata;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic idle(input int n);
        req_valid = 0; req_write = 0; req_fault = 0;
        hang_rd = 0; hang_wr = 0; err_rd = 0; err_wr = 0;
        wait_rd = 0; wait_wr = 0; sb_mode = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts an op in the current IDLE cycle; returns #1 into the cycle after DONE.
    task automatic run_op(input string name, input bit wr, input bit flt, input logic [31:0] addr,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_cycle,
                          input int exp_writes, input int exp_reqs, input int budget);
        exp_t e, got;
        int   c;
        bit   found, stall_ok;
        e.rdata = exp_rdata; e.err = exp_err; e.cycle = exp_cycle;
        e.writes = exp_writes; e.reqs = exp_reqs;
        sb.push_back(e);
        req_cycles = 0; wr_count = 0; first_seen = 0;
        req_valid = 1; req_write = wr; req_fault = flt; req_addr = addr;
        found = 0; stall_ok = 1;
        @(negedge clk);
        n_tests++;
        if (bus_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_bus_req: got %b want 0", name, bus_req);
        end
        for (c = 0; c < budget; c++) begin
            if (c > 0) @(negedge clk);
            if (done === 1'b1) begin
                found = 1;
                break;
            end
            if (stall !== 1'b1 || err !== 1'b0) stall_ok = 0;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
        end else begin
            got = sb.pop_front();
            if (c !== got.cycle) begin
                n_fail++;
                $display("FAIL %s done_cycle: got %0d want %0d", name, c, got.cycle);
            end
            n_tests++;
            if (err !== got.err || stall !== 1'b0) begin
                n_fail++;
                $display("FAIL %s err_stall: got err=%b stall=%b want err=%b stall=0", name, err, stall, got.err);
            end
            n_tests++;
            if (rdata !== got.rdata) begin
                n_fail++;
                $display("FAIL %s rdata: got %h want %h", name, rdata, got.rdata);
            end
            n_tests++;
            if (wr_count !== got.writes || req_cycles !== got.reqs) begin
                n_fail++;
                $display("FAIL %s bus_activity: got writes=%0d req_cycles=%0d want %0d/%0d",
                         name, wr_count, req_cycles, got.writes, got.reqs);
            end
            n_tests++;
            if (!stall_ok) begin
                n_fail++;
                $display("FAIL %s stall_before_done: stall not held high or early err", name);
            end
            if (got.reqs > 0) begin
                n_tests++;
                if (first_addr !== addr) begin
                    n_fail++;
                    $display("FAIL %s bus_addr: got %h want %h", name, first_addr, addr);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (rdata !== 32'h0 || bus_req !== 0 || bus_we !== 0 || done !== 0 || err !== 0 || stall !== 0) begin
            n_fail++;
            $display("FAIL reset_values: got rdata=%h req=%b we=%b done=%b err=%b stall=%b want all 0",
                     rdata, bus_req, bus_we, done, err, stall);
        end
        req_valid = 1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_follows_valid: got %b want 1", stall);
        end
        req_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        idle(1);
    endtask

    task automatic test_load();
        rd_word = 32'hABCD_AAAA;
        run_op("load", 0, 0, 32'hAAAA_0010, 32'hABCD_AAAA, 0, 2, 0, 1, 20);
        idle(2);
    endtask

    task automatic test_store();
        rd_word = 32'hAAAA_BBBB; sb_mode = 1; wait_rd = 2; wait_wr = 2;
        run_op("store", 1, 0, 32'h0000_0020, 32'hAAAA_BBBB, 0, 8, 1, 6, 30);
        n_tests++;
        if (wr_data !== 32'hFFAA_BBBB) begin
            n_fail++;
            $display("FAIL store_wdata: got %h want ffaabbbb", wr_data);
        end
        idle(2);
    endtask

    task automatic test_fault();
        run_op("fault", 1, 1, 32'h0000_0040, 32'hAAAA_BBBB, 1, 1, 0, 0, 20);
        idle(2);
    endtask

    task automatic test_bus_err();
        rd_word = 32'h5555_5555; err_rd = 1; sb_mode = 1;
        run_op("bus_err", 1, 0, 32'h0000_0080, 32'hAAAA_BBBB, 1, 2, 0, 1, 20);
        idle(2);
    endtask

    task automatic test_back_to_back();
        rd_word = 32'h1111_2222;
        run_op("b2b_first", 0, 0, 32'h0000_0100, 32'h1111_2222, 0, 2, 0, 1, 20);
        rd_word = 32'h3333_4444;
        run_op("b2b_second", 0, 0, 32'h0000_0104, 32'h3333_4444, 0, 2, 0, 1, 20);
        idle(2);
    endtask

    task automatic test_timeout();
`ifdef DMEM_TIMEOUT_EN
        hang_rd = 1;
        run_op("timeout", 0, 0, 32'h0000_0200, 32'h3333_4444, 1, 5, 0, 4, 30);
        idle(2);
`else
        bit ok;
        ok = 1;
        hang_rd = 1;
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0200;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (stall !== 1'b1 || done !== 1'b0) ok = 0;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL no_timeout_hold: stall dropped or done seen, last stall=%b done=%b want 1/0", stall, done);
        end
        @(posedge clk);
        #1;
        rst = 1; req_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        idle(2);
`endif
    endtask

    task automatic test_reset_mid_wr();
        bit no_done;
        rd_word = 32'h1234_5678; sb_mode = 1; hang_wr = 1;
        req_valid = 1; req_write = 1; req_fault = 0; req_addr = 32'h0000_0300;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL mid_wr_phase: got req=%b we=%b rdata=%h want 1/1/12345678", bus_req, bus_we, rdata);
        end
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0; req_valid = 0;
        @(negedge clk);
        n_tests++;
        if (bus_req !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_wr_reset: got req=%b rdata=%h want 0/0", bus_req, rdata);
        end
        no_done = 1;
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0) no_done = 0;
            @(negedge clk);
        end
        n_tests++;
        if (!no_done) begin
            n_fail++;
            $display("FAIL mid_wr_no_done: done pulsed after reset");
        end
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_fault();
        test_bus_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
